// File: rtl/lsu_pkg.sv
// Shared constants, types and lane helpers for the multi-cycle load/store unit.
// Decode is a pure function so the top can evaluate it once, at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] LEDR_BASE = 32'h0000_7000;
  localparam logic [31:0] LEDR_LIM  = 32'h0000_700F;
  localparam logic [31:0] LEDG_BASE = 32'h0000_7010;
  localparam logic [31:0] LEDG_LIM  = 32'h0000_701F;
  localparam logic [31:0] LCD_BASE  = 32'h0000_7020;
  localparam logic [31:0] LCD_LIM   = 32'h0000_702F;
  localparam logic [31:0] SW_BASE   = 32'h0000_7800;
  localparam logic [31:0] SW_LIM    = 32'h0000_780F;
  localparam logic [31:0] BTN_BASE  = 32'h0000_7810;
  localparam logic [31:0] BTN_LIM   = 32'h0000_781F;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef enum logic [2:0] {
    RG_DMEM, RG_LEDR, RG_LEDG, RG_LCD, RG_SW, RG_BTN, RG_NONE
  } region_e;

  typedef struct packed {
    region_e    region;
    logic       fault;
    logic [3:0] mask;
  } decode_t;

  function automatic region_e addr_region(input logic [31:0] addr, input int unsigned dmem_aw);
    region_e r;
    if ((addr >> (dmem_aw + 32'd2)) == 32'd0)         r = RG_DMEM;
    else if (addr >= LEDR_BASE && addr <= LEDR_LIM)    r = RG_LEDR;
    else if (addr >= LEDG_BASE && addr <= LEDG_LIM)    r = RG_LEDG;
    else if (addr >= LCD_BASE  && addr <= LCD_LIM)     r = RG_LCD;
    else if (addr >= SW_BASE   && addr <= SW_LIM)      r = RG_SW;
    else if (addr >= BTN_BASE  && addr <= BTN_LIM)     r = RG_BTN;
    else                                               r = RG_NONE;
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'b0001 << a;
      F3_H, F3_HU: m = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        m = 4'b1111;
      default:     m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_replicate(input logic [31:0] wdata, input logic [2:0] f3);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {4{wdata[7:0]}};
      F3_H:    r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  // Halfword/word accesses are aligned by the time this runs, so shifting by the full offset is safe.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {a, 3'b000};
    case (f3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   r = {24'h00_0000, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   r = {16'h0000, sh[15:0]};
      F3_W:    r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic decode_t decode(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                     input int unsigned dmem_aw);
    decode_t d;
    logic    bad_f3;
    logic    misal;
    logic    ro;
    d.region = addr_region(addr, dmem_aw);
    d.mask   = lane_mask(f3, addr[1:0]);
    if (we) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
    else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal   = ((f3 == F3_H || f3 == F3_HU) && addr[0]) || (f3 == F3_W && addr[1:0] != 2'b00);
    ro      = we && (d.region == RG_SW || d.region == RG_BTN);
    d.fault = bad_f3 || misal || ro || (d.region == RG_NONE);
    return d;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Byte-enable data RAM with a RD_LATENCY-deep registered read path.
// The read address is free-running; the caller holds it steady while waiting.
module lsu_dmem #(
  parameter int unsigned AW         = 11,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q  [2**AW];
  logic [31:0] pipe_q [RD_LATENCY];

  // Per-lane write so unselected bytes keep their contents
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  // Read pipeline
  always_ff @(posedge clk_i) begin
    pipe_q[0] <= mem_q[raddr_i];
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign rdata_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: request FSM, address decode, I/O registers and response mux.
// Requests are decoded once at acceptance; the commit happens on the last BUSY edge.
module lsu_mc
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_AW    = 11,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_funct3,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_err,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_lcd
);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [1:0]         addr_lo_q;
  logic [DMEM_AW-1:0] addr_w_q;
  logic [31:0]        wdata_q;
  decode_t            dec_q;
  logic [31:0]        sw_q;
  logic [3:0]         btn_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        ledr_q, ledg_q, lcd_q;

  decode_t            dec_s;
  logic               accept_s;
  logic               commit_s;
  logic               store_ok_s;
  logic [2:0]         lat_s;
  logic [DMEM_AW-1:0] raddr_s;
  logic [3:0]         dmem_we_s;
  logic [31:0]        dmem_rdata_s;
  logic [31:0]        src_s;

  assign dec_s      = decode(i_we, i_addr, i_funct3, DMEM_AW);
  assign accept_s   = i_req && (state_q == IDLE);
  assign commit_s   = (state_q == BUSY) && (cnt_q == 3'd1);
  assign store_ok_s = commit_s && we_q && !dec_q.fault;
  assign lat_s      = (!i_we && !dec_s.fault && dec_s.region == RG_DMEM) ? 3'(RD_LATENCY) : 3'd1;
  // Point the RAM at the incoming address while idle so the pipeline starts filling on the accept edge
  assign raddr_s    = (state_q == IDLE) ? i_addr[DMEM_AW+1:2] : addr_w_q;
  // Gated with reset so a store is dropped when reset coincides with the commit edge
  assign dmem_we_s  = (store_ok_s && i_rst_n && dec_q.region == RG_DMEM) ? dec_q.mask : 4'b0000;

  lsu_dmem #(
    .AW         (DMEM_AW),
    .RD_LATENCY (RD_LATENCY)
  ) u_dmem (
    .clk_i   (i_clk),
    .we_i    (dmem_we_s),
    .waddr_i (addr_w_q),
    .wdata_i (wdata_q),
    .raddr_i (raddr_s),
    .rdata_o (dmem_rdata_s)
  );

  // Load source selection by latched region
  always_comb begin
    src_s = 32'h0000_0000;
    case (dec_q.region)
      RG_DMEM: src_s = dmem_rdata_s;
      RG_LEDR: src_s = ledr_q;
      RG_LEDG: src_s = ledg_q;
      RG_LCD:  src_s = lcd_q;
      RG_SW:   src_s = sw_q;
      RG_BTN:  src_s = {28'h000_0000, btn_q};
      default: src_s = 32'h0000_0000;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req) state_d = BUSY; else state_d = IDLE;
      BUSY:    if (cnt_q == 3'd1) state_d = RESP; else state_d = BUSY;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state and response data
  always_comb begin
    o_ready  = (state_q == IDLE);
    o_rvalid = (state_q == RESP);
    if (state_q == RESP) begin
      o_rdata = rdata_q;
      o_err   = err_q;
    end else begin
      o_rdata = 32'h0000_0000;
      o_err   = 1'b0;
    end
  end

  // Busy down-counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                          cnt_q <= 3'd0;
    else if (accept_s)                     cnt_q <= lat_s;
    else if (state_q == BUSY && cnt_q != 3'd1) cnt_q <= cnt_q - 3'd1;
    else                                   cnt_q <= cnt_q;
  end

  // Request capture, commit and response data
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_lo_q <= 2'b00;
      addr_w_q  <= '0;
      wdata_q   <= 32'h0000_0000;
      dec_q     <= '0;
      sw_q      <= 32'h0000_0000;
      btn_q     <= 4'h0;
      rdata_q   <= 32'h0000_0000;
      err_q     <= 1'b0;
      ledr_q    <= 32'h0000_0000;
      ledg_q    <= 32'h0000_0000;
      lcd_q     <= 32'h0000_0000;
    end else begin
      if (accept_s) begin
        we_q      <= i_we;
        f3_q      <= i_funct3;
        addr_lo_q <= i_addr[1:0];
        addr_w_q  <= i_addr[DMEM_AW+1:2];
        wdata_q   <= store_replicate(i_wdata, i_funct3);
        dec_q     <= dec_s;
        sw_q      <= i_io_sw;
        btn_q     <= i_io_btn;
      end
      if (commit_s) begin
        err_q   <= dec_q.fault;
        rdata_q <= (dec_q.fault || we_q) ? 32'h0000_0000 : load_extend(src_s, f3_q, addr_lo_q);
      end
      if (store_ok_s) begin
        case (dec_q.region)
          RG_LEDR: ledr_q <= merge_lanes(ledr_q, wdata_q, dec_q.mask);
          RG_LEDG: ledg_q <= merge_lanes(ledg_q, wdata_q, dec_q.mask);
          RG_LCD:  lcd_q  <= merge_lanes(lcd_q,  wdata_q, dec_q.mask);
          default: ;
        endcase
      end
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;

endmodule
